// File: rtl/p4_adder_issue_stage.sv
// Purpose: request FIFO + registered result stage wrapped around the combinational P4 adder.
// Latency: a beat pushed at edge N is on out_* after edge N+1 when the output register is free.
// Backpressure: out_* hold while out_valid && !out_ready; in_ready drops when the FIFO is full.
module p4_adder_issue_stage #(
  parameter int NBIT  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NBIT-1:0]        in_a,
  input  logic [NBIT-1:0]        in_b,
  input  logic                   in_cin,
  output logic [NBIT-1:0]        add_a,
  output logic [NBIT-1:0]        add_b,
  output logic                   add_cin,
  input  logic [NBIT-1:0]        add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NBIT-1:0]        out_a,
  output logic [NBIT-1:0]        out_b,
  output logic                   out_cin,
  output logic [NBIT-1:0]        out_s,
  output logic                   out_cout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            cin;
  } req_t;

  req_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  req_t            head;
  logic            push;
  logic            load;

  logic            out_valid_q, out_valid_d;
  logic [NBIT-1:0] out_a_q, out_a_d;
  logic [NBIT-1:0] out_b_q, out_b_d;
  logic            out_cin_q, out_cin_d;
  logic [NBIT-1:0] out_s_q, out_s_d;
  logic            out_cout_q, out_cout_d;

  // in_ready depends only on reset and registered occupancy, never on out_ready
  assign in_ready = rst_n && (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = (count_q != '0) && (!out_valid_q || out_ready);

  // Head entry drives the adder; zeros when empty so the adder never sees stale/X data
  always_comb begin
    head = '0;
    if (count_q != '0) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign add_a   = head.a;
  assign add_b   = head.b;
  assign add_cin = head.cin;

  // Storage needs no reset: entries are only read when count says they were written
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: in_a, b: in_b, cin: in_cin};
    end
  end

  // Pointer and occupancy next state; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (load) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output register next state: capture head + adder result on load, hold under stall
  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_cin_d   = out_cin_q;
    out_s_d     = out_s_q;
    out_cout_d  = out_cout_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_a_d     = head.a;
      out_b_d     = head.b;
      out_cin_d   = head.cin;
      out_s_d     = add_s;
      out_cout_d  = add_cout;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops every buffered and registered beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_cin_q   <= 1'b0;
      out_s_q     <= '0;
      out_cout_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_cin_q   <= out_cin_d;
      out_s_q     <= out_s_d;
      out_cout_q  <= out_cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_cin   = out_cin_q;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign count     = count_q;

endmodule

// File: tb/tb_p4_adder_issue_stage.sv
// Directed bench for p4_adder_issue_stage with a behavioural adder closing the add_* loop.
// Inputs change on negedge; outputs are sampled on negedge after each posedge.
// Each scenario task does its own comparisons and steps total/bad.
module tb_p4_adder_issue_stage;
  localparam int NBIT  = 32;
  localparam int DEPTH = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] in_a, in_b;
  logic            in_cin;
  logic [NBIT-1:0] add_a, add_b;
  logic            add_cin;
  logic [NBIT-1:0] add_s;
  logic            add_cout;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] out_a, out_b;
  logic            out_cin;
  logic [NBIT-1:0] out_s;
  logic            out_cout;
  logic [1:0]      count;

  int total = 0;
  int bad   = 0;

  logic [NBIT:0] sum_full;
  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {{NBIT{1'b0}}, add_cin};
  assign add_s    = sum_full[NBIT-1:0];
  assign add_cout = sum_full[NBIT];

  p4_adder_issue_stage #(.NBIT(NBIT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_cin(out_cin),
    .out_s(out_s), .out_cout(out_cout),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_beat(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input logic c);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    set_beat(32'hAAAA_5555, 32'h1234_5678, 1'b1);
    cyc(); cyc();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (out_s !== 32'h0) begin bad++; $display("FAIL reset_out_s: got %h want 0", out_s); end
    total++; if (add_a !== 32'h0) begin bad++; $display("FAIL reset_add_a: got %h want 0", add_a); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    @(negedge clk);
    out_ready = 1'b1;
    set_beat(32'h0000_0005, 32'h0000_0003, 1'b1);
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    total++; if (count !== 2'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
    total++; if (add_a !== 32'h5) begin bad++; $display("FAIL single_head_a: got %h want 5", add_a); end
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
    total++; if (out_s !== 32'd9) begin bad++; $display("FAIL single_sum: got %h want 9", out_s); end
    total++; if (out_cout !== 1'b0) begin bad++; $display("FAIL single_cout: got %b want 0", out_cout); end
    total++; if (out_a !== 32'd5 || out_b !== 32'd3 || out_cin !== 1'b1)
      begin bad++; $display("FAIL single_echo: got a=%h b=%h cin=%b want 5 3 1", out_a, out_b, out_cin); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL single_count_after: got %0d want 0", count); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_carry();
    set_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    cyc(); in_valid = 1'b0; cyc();
    total++; if (out_s !== 32'h0 || out_cout !== 1'b1 || out_valid !== 1'b1)
      begin bad++; $display("FAIL carry_wrap: got v=%b s=%h c=%b want 1 0 1", out_valid, out_s, out_cout); end
    set_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    cyc(); in_valid = 1'b0; cyc();
    total++; if (out_s !== 32'hFFFF_FFFF || out_cout !== 1'b1 || out_valid !== 1'b1)
      begin bad++; $display("FAIL carry_max: got v=%b s=%h c=%b want 1 ffffffff 1", out_valid, out_s, out_cout); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL carry_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_beat(32'd1, 32'd1, 1'b0);
    cyc();
    total++; if (count !== 2'd1) begin bad++; $display("FAIL bp_count1: got %0d want 1", count); end
    set_beat(32'd2, 32'd2, 1'b0);
    cyc();
    total++; if (out_s !== 32'd2 || out_valid !== 1'b1)
      begin bad++; $display("FAIL bp_first: got v=%b s=%h want 1 2", out_valid, out_s); end
    set_beat(32'd3, 32'd3, 1'b0);
    cyc();
    total++; if (count !== 2'd2) begin bad++; $display("FAIL bp_full_count: got %0d want 2", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    total++; if (out_s !== 32'd2) begin bad++; $display("FAIL bp_hold1: got %h want 2", out_s); end
    set_beat(32'd4, 32'd4, 1'b0);
    cyc();
    total++; if (count !== 2'd2 || out_s !== 32'd2 || out_a !== 32'd1 || out_valid !== 1'b1)
      begin bad++; $display("FAIL bp_hold2: got cnt=%0d s=%h a=%h v=%b want 2 2 1 1", count, out_s, out_a, out_valid); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    total++; if (out_s !== 32'd4 || out_valid !== 1'b1 || count !== 2'd1)
      begin bad++; $display("FAIL bp_second: got s=%h v=%b cnt=%0d want 4 1 1", out_s, out_valid, count); end
    cyc();
    total++; if (out_s !== 32'd6 || out_valid !== 1'b1 || count !== 2'd0)
      begin bad++; $display("FAIL bp_third: got s=%h v=%b cnt=%0d want 6 1 0", out_s, out_valid, count); end
    cyc();
    total++; if (out_valid !== 1'b0 || count !== 2'd0)
      begin bad++; $display("FAIL bp_no_fourth: got v=%b cnt=%0d want 0 0", out_valid, count); end
  endtask

  task automatic test_streaming();
    logic [NBIT-1:0] ea [100];
    logic [NBIT-1:0] eb [100];
    logic            ec [100];
    logic [NBIT:0]   es;
    for (int i = 0; i < 100; i++) begin
      ea[i] = $urandom;
      eb[i] = $urandom;
      ec[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 102; k++) begin
      if (k < 100) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready k=%0d: got %b want 1", k, in_ready); end
        set_beat(ea[k], eb[k], ec[k]);
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      total++; if (count > 2'd1) begin bad++; $display("FAIL stream_count k=%0d: got %0d want <=1", k, count); end
      if (k == 0 || k == 101) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_idle k=%0d: got %b want 0", k, out_valid); end
      end else begin
        es = {1'b0, ea[k-1]} + {1'b0, eb[k-1]} + {{NBIT{1'b0}}, ec[k-1]};
        total++;
        if (out_valid !== 1'b1 || out_a !== ea[k-1] || out_b !== eb[k-1] || out_cin !== ec[k-1] ||
            out_s !== es[NBIT-1:0] || out_cout !== es[NBIT]) begin
          bad++;
          $display("FAIL stream_beat %0d: got v=%b s=%h c=%b a=%h want s=%h c=%b a=%h",
                   k-1, out_valid, out_s, out_cout, out_a, es[NBIT-1:0], es[NBIT], ea[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    set_beat(32'd1, 32'd1, 1'b0); cyc();
    set_beat(32'd2, 32'd2, 1'b0); cyc();
    set_beat(32'd3, 32'd3, 1'b0); cyc();
    total++; if (count !== 2'd2 || out_valid !== 1'b1)
      begin bad++; $display("FAIL mid_fill: got cnt=%0d v=%b want 2 1", count, out_valid); end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cyc();
    total++; if (count !== 2'd0 || out_valid !== 1'b0 || out_s !== 32'h0)
      begin bad++; $display("FAIL mid_reset: got cnt=%0d v=%b s=%h want 0 0 0", count, out_valid, out_s); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    set_beat(32'd7, 32'd8, 1'b0);
    cyc(); in_valid = 1'b0; cyc();
    total++; if (out_valid !== 1'b1 || out_s !== 32'd15 || out_a !== 32'd7)
      begin bad++; $display("FAIL mid_post_beat: got v=%b s=%h a=%h want 1 f 7", out_valid, out_s, out_a); end
    cyc();
    total++; if (out_valid !== 1'b0 || count !== 2'd0)
      begin bad++; $display("FAIL mid_no_replay1: got v=%b cnt=%0d want 0 0", out_valid, count); end
    cyc();
    total++; if (out_valid !== 1'b0 || count !== 2'd0)
      begin bad++; $display("FAIL mid_no_replay2: got v=%b cnt=%0d want 0 0", out_valid, count); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_carry();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
